// File: rtl/ram_req_ctrl_if.sv
// Request/response channel for ram_req_ctrl: in-order requests master->slave, read data back slave->master.
// Both directions use valid/ready; a transfer happens on a clock edge where valid && ready.
interface ram_req_ctrl_if #(
   parameter int Data_width = 32,
   parameter int Addr_width = 7
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [Addr_width-1:0] req_addr;
   logic [Data_width-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [Data_width-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/ram_req_ctrl.sv
// Front-end for a single-port sync RAM: clears it after reset, then serves in-order reads/writes; reads respond 2 cycles after acceptance.
// Backpressure: req_ready drops when buffered plus in-flight reads reach 3, so a stalled consumer never loses data.
module ram_req_ctrl #(
   parameter int                    Data_width = 32,
   parameter int                    Addr_width = 7,
   parameter logic [Data_width-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_req_ctrl_if.slave         bus,
   output logic                  init_done,
   output logic                  ram_we,
   output logic [Addr_width-1:0] ram_address,
   output logic [Data_width-1:0] ram_d,
   input  logic [Data_width-1:0] ram_q
);
   typedef enum logic {INIT, RUN} state_e;

   localparam logic [Addr_width:0] LAST_ADDR = (Addr_width+1)'((1 << Addr_width) - 1);
   localparam logic [Addr_width:0] CNT_ONE   = (Addr_width+1)'(1);

   state_e                state_q, state_d;
   logic [Addr_width:0]   cnt_q, cnt_d;
   logic                  init_done_q, init_done_d;
   logic                  pend_q, pend_d;
   logic [1:0]            occ_q, occ_d;
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   logic [Data_width-1:0] buf_q [3];
   logic                  req_rdy;
   logic                  rd_acc;
   logic                  push;
   logic                  pop;
   logic [2:0]            inflight;

   assign inflight = {1'b0, occ_q} + {2'b00, pend_q};
   assign push     = pend_q;
   assign pop      = (occ_q != 2'd0) && bus.rsp_ready;
   assign rd_acc   = bus.req_valid && req_rdy && !bus.req_we;
   assign pend_d   = rd_acc;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      req_rdy     = 1'b0;
      ram_we      = 1'b0;
      ram_address = bus.req_addr;
      ram_d       = bus.req_wdata;
      case (state_q)
         INIT: begin
            ram_we      = 1'b1;
            ram_address = cnt_q[Addr_width-1:0];
            ram_d       = INIT_VALUE;
            cnt_d       = cnt_q + CNT_ONE;
            if (cnt_q == LAST_ADDR) begin
               state_d     = RUN;
               init_done_d = 1'b1;
            end
         end
         RUN: begin
            // The pending read owns a slot, so its push can never overflow.
            req_rdy = (inflight < 3'd3);
            ram_we  = bus.req_valid && req_rdy && bus.req_we;
         end
      endcase
      if (rst) begin
         req_rdy = 1'b0;
         ram_we  = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         pend_q      <= 1'b0;
         occ_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         pend_q      <= pend_d;
         occ_q       <= occ_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         if (push) buf_q[wr_ptr_q] <= ram_q;
      end
   end

   assign bus.req_ready = req_rdy;
   assign bus.rsp_valid = (occ_q != 2'd0);
   assign bus.rsp_rdata = buf_q[rd_ptr_q];
   assign init_done     = init_done_q;
endmodule
